// File: rtl/seq_alu_pkg.sv
// Opcodes and controller state encoding shared by the ALU and its mul/div core.
// No logic of its own.
package seq_alu_pkg;

    localparam logic [3:0] OP_AND    = 4'h0;
    localparam logic [3:0] OP_OR     = 4'h1;
    localparam logic [3:0] OP_NEG    = 4'h2;
    localparam logic [3:0] OP_NOT    = 4'h3;
    localparam logic [3:0] OP_ADD    = 4'h4;
    localparam logic [3:0] OP_SUB    = 4'h5;
    localparam logic [3:0] OP_MUL    = 4'h6;
    localparam logic [3:0] OP_DIV    = 4'h7;
    localparam logic [3:0] OP_SHR    = 4'h8;
    localparam logic [3:0] OP_SHRA   = 4'h9;
    localparam logic [3:0] OP_SHL    = 4'hA;
    localparam logic [3:0] OP_ROR    = 4'hB;
    localparam logic [3:0] OP_ROL    = 4'hC;
    localparam logic [3:0] OP_INCPC  = 4'hD;
    localparam logic [3:0] OP_BRANCH = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative signed multiply (shift-add) / divide (non-restoring) on operand magnitudes; one bit per step_i,
// then fix_i applies sign and remainder correction in place. Driven entirely by the controller, no handshake.
module seq_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               load_i,
    input  logic               div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               step_i,
    input  logic               fix_i,
    output logic [2*WIDTH-1:0] res_o,
    output logic               last_o
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH:0]     hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d, d_q;
    logic               div_q, neg_q, neg_rem_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, rs, rn, rem;
    logic [2*WIDTH:0]   mul_sh;
    logic [2*WIDTH-1:0] prod, prod_n;

    assign a_mag  = a_i[WIDTH-1] ? -a_i : a_i;
    assign b_mag  = b_i[WIDTH-1] ? -b_i : b_i;
    assign res_o  = {hi_q[WIDTH-1:0], lo_q};
    assign last_o = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        mul_sum = '0;
        mul_sh  = '0;
        rs      = '0;
        rn      = '0;
        rem     = '0;
        prod    = {hi_q[WIDTH-1:0], lo_q};
        prod_n  = -prod;
        if (load_i) begin
            hi_d = '0;
            lo_d = div_i ? a_mag : b_mag;
        end else if (step_i) begin
            if (div_q) begin
                // Partial remainder sign picks add or subtract; quotient bit is its complement.
                rs   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
                rn   = hi_q[WIDTH] ? rs + {1'b0, d_q} : rs - {1'b0, d_q};
                hi_d = rn;
                lo_d = {lo_q[WIDTH-2:0], ~rn[WIDTH]};
            end else begin
                mul_sum = {1'b0, hi_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, d_q} : '0);
                mul_sh  = {mul_sum, lo_q};
                hi_d    = {1'b0, mul_sh[2*WIDTH:WIDTH+1]};
                lo_d    = mul_sh[WIDTH:1];
            end
        end else if (fix_i) begin
            if (div_q) begin
                rem  = hi_q[WIDTH] ? hi_q + {1'b0, d_q} : hi_q;
                hi_d = {1'b0, neg_rem_q ? -rem[WIDTH-1:0] : rem[WIDTH-1:0]};
                lo_d = neg_q ? -lo_q : lo_q;
            end else begin
                hi_d = {1'b0, neg_q ? prod_n[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH]};
                lo_d = neg_q ? prod_n[WIDTH-1:0] : prod[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hi_q      <= '0;
            lo_q      <= '0;
            d_q       <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            if (load_i) begin
                d_q       <= div_i ? b_mag : a_mag;
                div_q     <= div_i;
                neg_q     <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
                neg_rem_q <= a_i[WIDTH-1];
                cnt_q     <= '0;
            end else if (step_i) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops land in C on the start edge; MUL/DIV take WIDTH+2 edges with busy high.
// No backpressure: start is simply ignored while busy.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   Y,
    input  logic [WIDTH-1:0]   BusMuxOut,
    output logic [2*WIDTH-1:0] C,
    output logic               busy,
    output logic               done,
    output logic               div_zero
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t               state_q;
    logic [2*WIDTH-1:0]   c_q;
    logic                 busy_q, done_q, dz_q, fix_q;
    logic [WIDTH-1:0]     lo_res;
    logic [2*WIDTH-1:0]   rot;
    logic [SHAMT_W-1:0]   sh;
    logic                 md_go, dz_go, core_last;
    logic [2*WIDTH-1:0]   core_res;

    assign sh    = BusMuxOut[SHAMT_W-1:0];
    assign md_go = (op == OP_MUL) || ((op == OP_DIV) && (BusMuxOut != '0));
    assign dz_go = (op == OP_DIV) && (BusMuxOut == '0);

    always_comb begin
        lo_res = '0;
        rot    = '0;
        case (op)
            OP_AND:    lo_res = Y & BusMuxOut;
            OP_OR:     lo_res = Y | BusMuxOut;
            OP_NEG:    lo_res = -Y;
            OP_NOT:    lo_res = ~Y;
            OP_ADD:    lo_res = Y + BusMuxOut;
            OP_SUB:    lo_res = Y - BusMuxOut;
            OP_SHR:    lo_res = Y >> sh;
            OP_SHRA:   lo_res = $signed(Y) >>> sh;
            OP_SHL:    lo_res = Y << sh;
            OP_ROR: begin
                rot    = {Y, Y} >> sh;
                lo_res = rot[WIDTH-1:0];
            end
            OP_ROL: begin
                rot    = {Y, Y} << sh;
                lo_res = rot[2*WIDTH-1:WIDTH];
            end
            OP_INCPC:  lo_res = BusMuxOut + ONE;
            OP_BRANCH: lo_res = Y + BusMuxOut + ONE;
            default:   lo_res = '0;
        endcase
    end

    seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .clr    (clr),
        .load_i (state_q == ST_IDLE && start && md_go),
        .div_i  (op == OP_DIV),
        .a_i    (Y),
        .b_i    (BusMuxOut),
        .step_i (state_q == ST_RUN),
        .fix_i  (state_q == ST_FIX && !fix_q),
        .res_o  (core_res),
        .last_o (core_last)
    );

    // FIX spans two edges: the core corrects in place, then the corrected value is written to C.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            fix_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (md_go) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end else if (dz_go) begin
                            c_q    <= {Y, {WIDTH{1'b1}}};
                            done_q <= 1'b1;
                            dz_q   <= 1'b1;
                        end else begin
                            c_q    <= {{WIDTH{1'b0}}, lo_res};
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (core_last) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    if (fix_q) begin
                        c_q     <= core_res;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        fix_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        fix_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign C        = c_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule
